// File: rtl/wave_mem_reader.sv
// Waveform memory reader: each rising edge of memclk advances an 8-bit phase
// address and emits one DAC sample from the waveform selected by memmode.
module wave_mem_reader #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] MIDSCALE = 8'h80
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_memclk,
  input  logic [1:0]        i_memmode,
  input  logic              i_sync_clr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_dac_valid,
  output logic              o_period_done,
  output logic [ADDR_W-1:0] o_cur_addr
);

  localparam logic [1:0] MODE_SINE   = 2'b00;
  localparam logic [1:0] MODE_SQUARE = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_SAW    = 2'b11;

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [6:0] quarter_sine(input logic [6:0] idx);
    logic [6:0] v;
    case (idx)
      7'd0:  v = 7'd0;
      7'd1:  v = 7'd3;
      7'd2:  v = 7'd6;
      7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;
      7'd5:  v = 7'd16;
      7'd6:  v = 7'd19;
      7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;
      7'd9:  v = 7'd28;
      7'd10: v = 7'd31;
      7'd11: v = 7'd34;
      7'd12: v = 7'd37;
      7'd13: v = 7'd40;
      7'd14: v = 7'd43;
      7'd15: v = 7'd46;
      7'd16: v = 7'd49;
      7'd17: v = 7'd51;
      7'd18: v = 7'd54;
      7'd19: v = 7'd57;
      7'd20: v = 7'd60;
      7'd21: v = 7'd63;
      7'd22: v = 7'd65;
      7'd23: v = 7'd68;
      7'd24: v = 7'd71;
      7'd25: v = 7'd73;
      7'd26: v = 7'd76;
      7'd27: v = 7'd78;
      7'd28: v = 7'd81;
      7'd29: v = 7'd83;
      7'd30: v = 7'd85;
      7'd31: v = 7'd88;
      7'd32: v = 7'd90;
      7'd33: v = 7'd92;
      7'd34: v = 7'd94;
      7'd35: v = 7'd96;
      7'd36: v = 7'd98;
      7'd37: v = 7'd100;
      7'd38: v = 7'd102;
      7'd39: v = 7'd104;
      7'd40: v = 7'd106;
      7'd41: v = 7'd107;
      7'd42: v = 7'd109;
      7'd43: v = 7'd111;
      7'd44: v = 7'd112;
      7'd45: v = 7'd113;
      7'd46: v = 7'd115;
      7'd47: v = 7'd116;
      7'd48: v = 7'd117;
      7'd49: v = 7'd118;
      7'd50: v = 7'd120;
      7'd51: v = 7'd121;
      7'd52: v = 7'd122;
      7'd53: v = 7'd122;
      7'd54: v = 7'd123;
      7'd55: v = 7'd124;
      7'd56: v = 7'd125;
      7'd57: v = 7'd125;
      7'd58: v = 7'd126;
      7'd59: v = 7'd126;
      7'd60: v = 7'd126;
      7'd61: v = 7'd127;
      7'd62: v = 7'd127;
      7'd63: v = 7'd127;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  logic              r_memclk_d;
  logic [1:0]        r_mode_q;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [1:0]        r_s1_mode;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_dac_data;
  logic              r_dac_valid;
  logic              r_period_done;

  logic              w_rise;
  logic [7:0]        w_a;
  logic [1:0]        w_quad;
  logic [6:0]        w_idx;
  logic [6:0]        w_qval;
  logic [7:0]        w_sine;
  logic [8:0]        w_tri9;
  logic [7:0]        w_sample;

  assign w_rise = i_memclk & ~r_memclk_d;

  // Clear and mode change both restart the period and swallow a coincident rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_memclk_d <= 1'b1;
      r_mode_q   <= MODE_SINE;
      r_addr     <= '0;
      r_s1_addr  <= '0;
      r_s1_mode  <= MODE_SINE;
      r_s1_valid <= 1'b0;
    end else begin
      r_memclk_d <= i_memclk;
      if (i_sync_clr) begin
        r_addr     <= '0;
        r_s1_valid <= 1'b0;
      end else if (i_memmode != r_mode_q) begin
        r_mode_q   <= i_memmode;
        r_addr     <= '0;
        r_s1_valid <= 1'b0;
      end else if (w_rise) begin
        r_s1_addr  <= r_addr;
        r_s1_mode  <= r_mode_q;
        r_s1_valid <= 1'b1;
        r_addr     <= r_addr + ADDR_W'(1);
      end else begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  assign w_a = r_s1_addr;

  // Sine folds the quarter table by quadrant; triangle is formed 9 bits wide.
  always_comb begin
    w_quad   = w_a[7:6];
    w_idx    = w_quad[0] ? (7'd64 - {1'b0, w_a[5:0]}) : {1'b0, w_a[5:0]};
    w_qval   = quarter_sine(w_idx);
    w_sine   = w_quad[1] ? (8'd128 - {1'b0, w_qval}) : (8'd128 + {1'b0, w_qval});
    w_tri9   = w_a[7] ? (9'd511 - {w_a, 1'b0}) : {w_a, 1'b0};
    w_sample = w_a;
    case (r_s1_mode)
      MODE_SINE:   w_sample = w_sine;
      MODE_SQUARE: w_sample = w_a[7] ? 8'd0 : 8'd255;
      MODE_TRI:    w_sample = w_tri9[7:0];
      MODE_SAW:    w_sample = w_a;
      default:     w_sample = w_a;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dac_data    <= MIDSCALE;
      r_dac_valid   <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_dac_valid   <= r_s1_valid;
      r_period_done <= r_s1_valid & (r_s1_addr == {ADDR_W{1'b1}});
      if (r_s1_valid) begin
        r_dac_data <= w_sample;
      end
    end
  end

  assign o_dac_data    = r_dac_data;
  assign o_dac_valid   = r_dac_valid;
  assign o_period_done = r_period_done;
  assign o_cur_addr    = r_addr;

endmodule

// File: tb/tb_wave_mem_reader.sv
// Scoreboard bench for wave_mem_reader: stimulus pushes expected samples,
// a negedge monitor pops and compares whenever dac_valid is seen.
module tb_wave_mem_reader;

  localparam real PI = 3.14159265358979;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       memclk = 1'b1;
  logic [1:0] memmode = 2'b11;
  logic       sync_clr = 1'b0;
  logic [7:0] dac_data;
  logic       dac_valid;
  logic       period_done;
  logic [7:0] cur_addr;

  typedef struct packed {
    logic [7:0] data;
    logic       pd;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   testCount = 0;
  int   failCount = 0;
  int   validCount = 0;
  int   pdCount = 0;
  int   pushCount = 0;

  wave_mem_reader dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_memclk      (memclk),
    .i_memmode     (memmode),
    .i_sync_clr    (sync_clr),
    .o_dac_data    (dac_data),
    .o_dac_valid   (dac_valid),
    .o_period_done (period_done),
    .o_cur_addr    (cur_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [7:0] data, input logic pd);
    exp_t e;
    e.data = data;
    e.pd   = pd;
    expQ.push_back(e);
    pushCount++;
  endtask

  // One isolated memclk pulse (high 3 cycles, low 5), called at a negedge.
  task automatic applyStimulus(input bit expectSample, input logic [7:0] expData, input logic expPd);
    memclk = 1'b1;
    if (expectSample) pushExp(expData, expPd);
    repeat (3) @(negedge clk);
    memclk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  function automatic logic [7:0] sineModel(input int a);
    int q, r, idx, qv;
    q   = a / 64;
    r   = a % 64;
    idx = (q == 1 || q == 3) ? 64 - r : r;
    qv  = int'($floor(127.0 * $sin(2.0 * PI * idx / 256.0) + 0.5));
    return (q < 2) ? 8'(128 + qv) : 8'(128 - qv);
  endfunction

  always @(negedge clk) begin
    if (dac_valid !== 1'b0) begin
      validCount++;
      if (period_done === 1'b1) pdCount++;
      if (expQ.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL unexpected_sample: got dac_valid=%b data=%0d, expected no sample", dac_valid, dac_data);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sample_data", {24'd0, dac_data}, {24'd0, monExp.data});
        checkOutput("sample_period_done", {31'd0, period_done}, {31'd0, monExp.pd});
      end
    end else if (period_done !== 1'b0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL stray_period_done: got %b, expected 0", period_done);
    end
  end

  initial begin
    int vBase, pBase;
    logic [7:0] e;

    // Reset release with memclk already high must not count as an edge.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_dac_data", dac_data, 8'h80);
    checkOutput("reset_dac_valid", dac_valid, 0);
    checkOutput("reset_cur_addr", cur_addr, 0);
    repeat (4) @(negedge clk);
    checkOutput("held_high_cur_addr", cur_addr, 0);
    checkOutput("held_high_dac_data", dac_data, 8'h80);
    memclk = 1'b0;
    @(negedge clk);
    memclk = 1'b1;
    pushExp(8'h00, 1'b0);
    @(negedge clk);
    checkOutput("latency_cycle1_valid", dac_valid, 0);
    @(negedge clk);
    checkOutput("latency_cycle2_valid", dac_valid, 1);
    checkOutput("first_cur_addr", cur_addr, 1);
    repeat (2) @(negedge clk);
    memclk = 1'b0;
    repeat (5) @(negedge clk);

    // Sawtooth full period after a standalone clear.
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    @(negedge clk);
    checkOutput("clear_cur_addr", cur_addr, 0);
    vBase = validCount;
    pBase = pdCount;
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'(i), i == 255);
    checkOutput("saw_cur_addr_wrap", cur_addr, 0);
    checkOutput("saw_valid_count", validCount - vBase, 256);
    checkOutput("saw_period_done_count", pdCount - pBase, 1);

    // Sine full period; key points are hand constants.
    memmode = 2'b00;
    repeat (2) @(negedge clk);
    checkOutput("sine_mode_cur_addr", cur_addr, 0);
    for (int i = 0; i < 256; i++) begin
      case (i)
        0:       e = 8'd128;
        64:      e = 8'd255;
        128:     e = 8'd128;
        192:     e = 8'd1;
        default: e = sineModel(i);
      endcase
      applyStimulus(1'b1, e, i == 255);
    end

    // Triangle then square full periods.
    memmode = 2'b10;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      e = (i < 128) ? 8'(2 * i) : 8'(511 - 2 * i);
      applyStimulus(1'b1, e, i == 255);
    end
    memmode = 2'b01;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, (i < 128) ? 8'd255 : 8'd0, i == 255);

    // Mode change coincident with a rise drops that rise.
    memmode = 2'b11;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("pre_switch_cur_addr", cur_addr, 10);
    memmode = 2'b01;
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("switch_cur_addr", cur_addr, 0);
    applyStimulus(1'b1, 8'd255, 1'b0);
    checkOutput("switch_next_cur_addr", cur_addr, 1);

    // sync_clr coincident with a rise at addr 37, then sync_clr alone at addr 5.
    memmode = 2'b11;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 37; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("pre_clear_cur_addr", cur_addr, 37);
    memclk = 1'b1;
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    repeat (2) @(negedge clk);
    memclk = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("clear_on_rise_cur_addr", cur_addr, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("pre_solo_clear_cur_addr", cur_addr, 5);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    @(negedge clk);
    checkOutput("solo_clear_cur_addr", cur_addr, 0);
    applyStimulus(1'b1, 8'd0, 1'b0);

    // Reset with a sample in flight: no dac_valid may escape.
    memclk = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_dac_valid", dac_valid, 0);
    checkOutput("midreset_dac_data", dac_data, 8'h80);
    checkOutput("midreset_cur_addr", cur_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post_reset_cur_addr", cur_addr, 0);
    memclk = 1'b0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("total_sample_count", validCount, pushCount);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/wave_mem_reader.md
Name: wave_mem_reader

Overview:
- Consumer end of the memclk/memmode interface driven by the frequency/control block.
- Each rising edge of memclk (same clk domain) advances an 8-bit phase address and emits one DAC sample.
- The sample comes from the waveform selected by memmode: sine, square, triangle or sawtooth.
- Output feeds the DAC register; the sample rate is set entirely by the upstream memclk pulse spacing.

Parameters:
- ADDR_W, 8, phase address width (256 samples per period); the fixed waveform formulas below assume 8.
- DATA_W, 8, DAC sample width, unsigned offset-binary.
- MIDSCALE, 8'h80, dac_data value after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memclk  in  1  sample-advance strobe from the control block. Level may stay high for more than one cycle; only rising edges count.
- memmode  in  2  waveform select: 00 sine, 01 square, 10 triangle, 11 sawtooth.
- sync_clr  in  1  synchronous period restart; forces phase address to 0.
- dac_data  out  DATA_W  registered sample to DAC.
- dac_valid  out  1  one-cycle pulse when dac_data takes a new sample.
- period_done  out  1  one-cycle pulse, coincident with dac_valid, when the emitted sample used address 255.
- cur_addr  out  ADDR_W  current phase address (next address to be sampled).

Behaviour:
- Interface decision: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - dac_data = MIDSCALE; dac_valid = 0; period_done = 0; cur_addr = 0.
  - Internal mode_q = 00; memclk_d = 1, so a memclk already high at reset release is not counted as an edge.
  - Pipeline valid flags = 0.
- Edge detect: rise = memclk & ~memclk_d; memclk_d <= memclk every cycle.
- Stage 0, cycle N, priority order:
  1. sync_clr = 1: addr <= 0; any rise this cycle is dropped; no sample issued.
  2. memmode != mode_q: mode_q <= memmode; addr <= 0; s1_valid <= 0; any rise this cycle is dropped.
  3. rise: s1_addr <= addr; s1_mode <= mode_q; s1_valid <= 1; addr <= addr + 1, wrapping 255 -> 0.
  4. Otherwise: s1_valid <= 0.
- Stage 1, cycle N+1: compute the sample from s1_addr (a) and s1_mode.
  - Register into dac_data only when s1_valid.
  - dac_valid <= s1_valid; period_done <= s1_valid & (a == 255).
  - When not valid, dac_data holds its value.
- Latency: a rise in cycle N gives dac_data/dac_valid visible in cycle N+2. Maximum throughput is one sample per 2 cycles, since a rise needs a low cycle before it.
- Sine (00):
  - Quarter table Q[k] = round(127*sin(2*pi*k/256)), k = 0..64, 65 entries; Q[0] = 0, Q[64] = 127.
  - Quadrant q = a[7:6]. idx = a[5:0] for q = 0 or 2; idx = 64 - a[5:0] for q = 1 or 3.
  - Value = 128 + Q[idx] for q = 0 or 1; 128 - Q[idx] for q = 2 or 3.
  - Range 1..255. Key points: a=0 -> 128, a=64 -> 255, a=128 -> 128, a=192 -> 1.
- Square (01): a[7] == 0 ? 255 : 0.
- Triangle (10): a < 128 ? 2*a : 511 - 2*a, computed 9-bit and truncated to 8. Values: a=127 -> 254, a=128 -> 255, a=255 -> 1.
- Sawtooth (11): value = a.
- A mode change does not alter dac_data until the next emitted sample. The new waveform starts at address 0.
- The stage-1 sample already in flight when mode changes is still emitted, using its captured s1_mode.
- cur_addr = addr register; it updates the cycle after a rise, clear or mode change.
- Reset asserted mid-pipeline: all state returns to reset values immediately; no partial dac_valid pulse.

Test Plan:
- Reset release with memclk held high, memmode=11 -> no dac_valid, dac_data=0x80, cur_addr=0. Then memclk low 1 cycle, high -> dac_valid 2 cycles after the rise, dac_data=0x00, cur_addr=1.
- memmode=11, 256 isolated memclk pulses (high 3 cycles, low 5) -> exactly 256 dac_valid pulses; dac_data = 0..255 in order; one period_done, coincident with dac_data=255; cur_addr back to 0.
- memmode=00, 256 pulses -> samples at addresses 0/64/128/192 are 128/255/128/1. All 256 samples match the quarter-table model bit-exactly; sequence is symmetric.
- memmode=10 then 01 across full periods -> triangle 0,2,...,254,255,253,...,1; square 128 x 255 then 128 x 0.
- After 10 pulses in mode 11, switch memmode to 01 in the same cycle as a rise -> that rise produces no dac_valid, cur_addr=0. Next rise gives dac_data=255 (square, a=0).
- sync_clr coincident with a rise at addr=37 -> no sample, cur_addr=0. sync_clr alone at addr=5 -> next sample uses a=0.
